// File: rtl/sprite_write_arbiter.sv
// rtl/sprite_write_arbiter.sv - two-port round-robin arbiter for the sprite-register write port
//
// Shares the sprite controller's single write port (MW/address/data) between
// port 0 (processor store path) and port 1 (UI sequencer). At most one write
// is granted per clock. The grant is registered, so the strobe, address, data
// and the winner's ack all appear one cycle after the request is sampled.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   req0_i/addr0_i/data0_i     port 0 request, address, data
//   ack0_o                     port 0 write accepted (one-cycle pulse)
//   req1_i/addr1_i/data1_i     port 1 request, address, data
//   ack1_o                     port 1 write accepted (one-cycle pulse)
//   v_en_i                     active-video flag (used only with the gate option)
//   MW_o/address_o/data_o      write strobe, address, data to sprite controller
//   wr_count_o                 free-running count of issued writes (wraps)
//
// Option macro SPRITE_VBLANK_GATE_EN: when defined, no grant is made while
// v_en_i=1; otherwise v_en_i is ignored.

module sprite_write_arbiter #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] data0_i,
   output logic              ack0_o,
   input  logic              req1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] data1_i,
   output logic              ack1_o,
   input  logic              v_en_i,
   output logic              MW_o,
   output logic [ADDR_W-1:0] address_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  wr_count_o
);

   // ptr: port preferred when both are eligible (0 or 1).
   logic ptr;
   // maskN is high in the cycle after port N was granted; the requester still
   // holds its request while it sees the ack, and the mask stops that held
   // request from winning a second time.
   logic mask0;
   logic mask1;
   logic gate_ok;
   logic elig0;
   logic elig1;
   logic gnt0;
   logic gnt1;

`ifdef SPRITE_VBLANK_GATE_EN
   // Grants are held off during active video; a write already registered
   // still completes because only the decision is gated.
   assign gate_ok = ~v_en_i;
`else
   logic unused_v_en;
   assign unused_v_en = v_en_i;
   assign gate_ok     = 1'b1;
`endif

   assign elig0 = req0_i & ~mask0 & gate_ok;
   assign elig1 = req1_i & ~mask1 & gate_ok;

   // A lone eligible port wins; on contention the pointer decides.
   assign gnt0 = elig0 & (~elig1 | ~ptr);
   assign gnt1 = elig1 & (~elig0 |  ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= 1'b0;
         mask0      <= 1'b0;
         mask1      <= 1'b0;
         MW_o       <= 1'b0;
         ack0_o     <= 1'b0;
         ack1_o     <= 1'b0;
         address_o  <= '0;
         data_o     <= '0;
         wr_count_o <= '0;
      end else begin
         MW_o       <= gnt0 | gnt1;
         ack0_o     <= gnt0;
         ack1_o     <= gnt1;
         mask0      <= gnt0;
         mask1      <= gnt1;
         wr_count_o <= wr_count_o + {{(CNT_W-1){1'b0}}, MW_o};
         if (gnt0) begin
            address_o <= addr0_i;
            data_o    <= data0_i;
            ptr       <= 1'b1;
         end else if (gnt1) begin
            address_o <= addr1_i;
            data_o    <= data1_i;
            ptr       <= 1'b0;
         end
      end
   end

endmodule
